// File: rtl/ay_bus_sched.sv
// TurboSound PSG bus scheduler: CPU-decoded BC1/BDIR strobes for two AY chips,
// interleaved with service register writes that restore the CPU-latched address.
module ay_bus_sched #(
  parameter int unsigned PH_LEN  = 4,
  parameter int unsigned GAP_LEN = 2
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       ck35_i,
  input  logic       a15_i,
  input  logic       a14_i,
  input  logic       a1_i,
  input  logic [7:0] d_i,
  input  logic       ioreq_i,
  input  logic       wr_i,
  input  logic       svc_req_i,
  input  logic       svc_chip_i,
  input  logic [3:0] svc_reg_i,
  input  logic [7:0] svc_data_i,
  output logic       svc_ack_o,
  output logic       ay_clk_o,
  output logic       ay0_bc1_o,
  output logic       ay0_bdir_o,
  output logic       ay1_bc1_o,
  output logic       ay1_bdir_o,
  output logic [7:0] ay_dout_o,
  output logic       ay_dout_oe_o,
  output logic       chip_sel_o,
  output logic       d_out_active_o,
  output logic       ext_wait_cycle2_o,
  output logic       cpu_wait_o
);

  localparam int unsigned MAXLEN = (PH_LEN > GAP_LEN) ? PH_LEN : GAP_LEN;
  localparam int unsigned CW     = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] PH_LAST  = CW'(PH_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_G1, S_WRITE, S_G2, S_RESTORE, S_G3, S_ACK
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            ay_clk_q, ay_clk_d;
  logic            chip_sel_q, chip_sel_d;
  logic [1:0][3:0] shadow_q, shadow_d;
  logic            cpu_bc1_q, cpu_bc1_d;
  logic            cpu_bdir_q, cpu_bdir_d;
  logic            cpu_chip_q, cpu_chip_d;
  logic            svc_chip_q, svc_chip_d;
  logic [3:0]      svc_reg_q, svc_reg_d;
  logic [7:0]      svc_data_q, svc_data_d;

  logic hit, latch, write, read, ts_sel, idle, accept;
  logic svc_bc1, svc_bdir, svc_oe, svc_ack;
  logic [7:0] svc_dout;

  assign hit    = en_i & ioreq_i & a15_i & ~a1_i;
  assign latch  = hit & a14_i & wr_i;
  assign write  = hit & ~a14_i & wr_i;
  assign read   = hit & a14_i & ~wr_i;
  assign ts_sel = latch & (d_i[7:1] == 7'h7F);
  assign idle   = (state_q == S_IDLE);
  // The CPU wins a tie with a pending service request.
  assign accept = idle & svc_req_i & ~hit;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = S_LATCH;
      end
      S_LATCH:   if (cnt_q == PH_LAST)  begin state_d = S_G1;      cnt_d = '0; end
      S_G1:      if (cnt_q == GAP_LAST) begin state_d = S_WRITE;   cnt_d = '0; end
      S_WRITE:   if (cnt_q == PH_LAST)  begin state_d = S_G2;      cnt_d = '0; end
      S_G2:      if (cnt_q == GAP_LAST) begin state_d = S_RESTORE; cnt_d = '0; end
      S_RESTORE: if (cnt_q == PH_LAST)  begin state_d = S_G3;      cnt_d = '0; end
      S_G3:      if (cnt_q == GAP_LAST) begin state_d = S_ACK;     cnt_d = '0; end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Gap states keep driving the previous phase's byte so the PSG data bus never glitches.
  always_comb begin
    svc_bc1  = 1'b0;
    svc_bdir = 1'b0;
    svc_oe   = 1'b0;
    svc_ack  = 1'b0;
    svc_dout = '0;
    case (state_q)
      S_LATCH:   begin svc_bc1 = 1'b1; svc_bdir = 1'b1; svc_oe = 1'b1; svc_dout = {4'h0, svc_reg_q}; end
      S_G1:      begin svc_oe = 1'b1; svc_dout = {4'h0, svc_reg_q}; end
      S_WRITE:   begin svc_bdir = 1'b1; svc_oe = 1'b1; svc_dout = svc_data_q; end
      S_G2:      begin svc_oe = 1'b1; svc_dout = svc_data_q; end
      S_RESTORE: begin svc_bc1 = 1'b1; svc_bdir = 1'b1; svc_oe = 1'b1; svc_dout = {4'h0, shadow_q[svc_chip_q]}; end
      S_G3:      begin svc_oe = 1'b1; svc_dout = {4'h0, shadow_q[svc_chip_q]}; end
      S_ACK:     svc_ack = 1'b1;
      default:   svc_ack = 1'b0;
    endcase
  end

  // chip_sel and shadow only move while idle, so a stalled CPU access lands after the sequence.
  always_comb begin
    ay_clk_d   = ay_clk_q ^ ck35_i;
    chip_sel_d = chip_sel_q;
    shadow_d   = shadow_q;
    if (idle && latch) begin
      if (ts_sel)                  chip_sel_d = ~d_i[0];
      else if (d_i[7:4] == 4'h0)   shadow_d[chip_sel_q] = d_i[3:0];
    end
    cpu_bc1_d  = idle & ~ts_sel & (latch | read);
    cpu_bdir_d = idle & ~ts_sel & (latch | write);
    cpu_chip_d = chip_sel_q;
    svc_chip_d = accept ? svc_chip_i : svc_chip_q;
    svc_reg_d  = accept ? svc_reg_i  : svc_reg_q;
    svc_data_d = accept ? svc_data_i : svc_data_q;
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      ay_clk_q   <= 1'b0;
      chip_sel_q <= 1'b0;
      shadow_q   <= '0;
      cpu_bc1_q  <= 1'b0;
      cpu_bdir_q <= 1'b0;
      cpu_chip_q <= 1'b0;
      svc_chip_q <= 1'b0;
      svc_reg_q  <= '0;
      svc_data_q <= '0;
    end else begin
      ay_clk_q   <= ay_clk_d;
      chip_sel_q <= chip_sel_d;
      shadow_q   <= shadow_d;
      cpu_bc1_q  <= cpu_bc1_d;
      cpu_bdir_q <= cpu_bdir_d;
      cpu_chip_q <= cpu_chip_d;
      svc_chip_q <= svc_chip_d;
      svc_reg_q  <= svc_reg_d;
      svc_data_q <= svc_data_d;
    end
  end

  assign ay0_bc1_o         = (svc_bc1  & ~svc_chip_q) | (cpu_bc1_q  & ~cpu_chip_q);
  assign ay0_bdir_o        = (svc_bdir & ~svc_chip_q) | (cpu_bdir_q & ~cpu_chip_q);
  assign ay1_bc1_o         = (svc_bc1  &  svc_chip_q) | (cpu_bc1_q  &  cpu_chip_q);
  assign ay1_bdir_o        = (svc_bdir &  svc_chip_q) | (cpu_bdir_q &  cpu_chip_q);
  assign ay_dout_o         = svc_dout;
  assign ay_dout_oe_o      = svc_oe;
  assign svc_ack_o         = svc_ack;
  assign ay_clk_o          = ay_clk_q;
  assign chip_sel_o        = chip_sel_q;
  assign d_out_active_o    = cpu_bc1_q & ~cpu_bdir_q;
  assign ext_wait_cycle2_o = cpu_bc1_q | cpu_bdir_q;
  assign cpu_wait_o        = hit & ~idle;

endmodule
